// File: rtl/rsa_pkg.sv
// Shared types and constants for the rsa_modexp Montgomery exponentiation engine.
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRE_M,
    PRE_X,
    SQR,
    MUL,
    POST
  } rsa_state_e;

  // Edges per Montgomery product: launch, one per operand bit, final subtract/writeback.
  function automatic int unsigned monpro_cycles(input int unsigned width);
    return width + 2;
  endfunction

endpackage

// File: rtl/mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod p.
// done_o/result_o are valid in the final cycle so the caller writes back on that edge.
module mont_mult
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CYC = monpro_cycles(WIDTH);
  localparam int unsigned CW  = $clog2(CYC);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH+1:0] s_q, s_d;
  logic [WIDTH+1:0] s_sum, s_odd;
  logic [WIDTH-1:0] s_sub;

  // cnt_q: 0 idle, 1..WIDTH iterating, WIDTH+1 final cycle.
  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    s_d   = s_q;
    s_sum = s_q + (a_q[0] ? {2'b00, b_i} : '0);
    s_odd = s_sum[0] ? (s_sum + {2'b00, p_i}) : s_sum;
    s_sub = s_q[WIDTH-1:0] - p_i;
    if (start_i) begin
      cnt_d = CW'(1);
      a_d   = a_i;
      s_d   = '0;
    end else if (cnt_q == CW'(CYC - 1)) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + CW'(1);
      a_d   = a_q >> 1;
      s_d   = s_odd >> 1;
    end
  end

  assign done_o   = (cnt_q == CW'(CYC - 1));
  assign result_o = (s_q >= {2'b00, p_i}) ? s_sub : s_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
      a_q   <= '0;
      s_q   <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      s_q   <= s_d;
    end
  end

endmodule

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiation c = m^e mod p (Montgomery domain).
// Optional RSA_CONST_TIME_EN: MUL runs for every exponent bit, written back only when e[i]=1.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start_cmd,
  input  logic             stop_cmd,
  input  logic [WIDTH-1:0] rsa_p,
  input  logic [WIDTH-1:0] rsa_e,
  input  logic [WIDTH-1:0] rsa_m,
  input  logic [WIDTH-1:0] rsa_const,
  output logic [WIDTH-1:0] rsa_c,
  output logic             eoc,
  output logic             busy,
  output logic             err
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef RSA_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  rsa_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             launch_q, launch_d;
  logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d, k_q, k_d;
  logic [WIDTH-1:0] mb_q, mb_d, xb_q, xb_d, c_q, c_d;
  logic             eoc_q, eoc_d, busy_q, busy_d, err_q, err_d;
  logic [WIDTH-1:0] mm_a, mm_b, mm_res;
  logic             mm_done, op_done;

  mont_mult #(.WIDTH(WIDTH)) u_mm (
    .clk      (clk),
    .rstb     (rstb),
    .en_i     (ena),
    .start_i  (launch_q),
    .a_i      (mm_a),
    .b_i      (mm_b),
    .p_i      (p_q),
    .done_o   (mm_done),
    .result_o (mm_res)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    launch_d = 1'b0;
    p_d = p_q;  e_d = e_q;  m_d = m_q;  k_d = k_q;
    mb_d = mb_q;  xb_d = xb_q;  c_d = c_q;
    eoc_d = eoc_q;  err_d = err_q;
    mm_a = xb_q;
    mm_b = xb_q;
    case (state_q)
      PRE_M:   begin mm_a = m_q;          mm_b = k_q; end
      PRE_X:   begin mm_a = WIDTH'(1);    mm_b = k_q; end
      MUL:     mm_a = mb_q;
      POST:    mm_b = WIDTH'(1);
      default: ;
    endcase
    // Ignore a stale done left over from an aborted product during the launch cycle.
    op_done = mm_done && !launch_q;

    if (state_q == IDLE) begin
      if (stop_cmd) begin
        eoc_d = 1'b0;
        err_d = 1'b0;
      end else if (start_cmd) begin
        if (!rsa_p[0]) begin
          err_d = 1'b1;
          eoc_d = 1'b1;
          c_d   = '0;
        end else begin
          p_d = rsa_p;  e_d = rsa_e;  m_d = rsa_m;  k_d = rsa_const;
          err_d    = 1'b0;
          eoc_d    = 1'b0;
          state_d  = PRE_M;
          launch_d = 1'b1;
        end
      end
    end else if (stop_cmd) begin
      state_d = IDLE;
    end else if (op_done) begin
      launch_d = 1'b1;
      case (state_q)
        PRE_M: begin
          mb_d    = mm_res;
          state_d = PRE_X;
        end
        PRE_X: begin
          xb_d    = mm_res;
          idx_d   = IW'(WIDTH - 1);
          state_d = SQR;
        end
        SQR: begin
          xb_d = mm_res;
          if (CONST_TIME || e_q[idx_q]) state_d = MUL;
          else if (idx_q == '0)         state_d = POST;
          else                          idx_d = idx_q - IW'(1);
        end
        MUL: begin
          if (e_q[idx_q]) xb_d = mm_res;
          if (idx_q == '0) state_d = POST;
          else begin
            idx_d   = idx_q - IW'(1);
            state_d = SQR;
          end
        end
        POST: begin
          c_d      = mm_res;
          eoc_d    = 1'b1;
          state_d  = IDLE;
          launch_d = 1'b0;
        end
        default: ;
      endcase
    end
    busy_d = (state_q != IDLE) && (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      launch_q <= 1'b0;
      p_q <= '0;  e_q <= '0;  m_q <= '0;  k_q <= '0;
      mb_q <= '0;  xb_q <= '0;  c_q <= '0;
      eoc_q <= 1'b0;  busy_q <= 1'b0;  err_q <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      launch_q <= launch_d;
      p_q <= p_d;  e_q <= e_d;  m_q <= m_d;  k_q <= k_d;
      mb_q <= mb_d;  xb_q <= xb_d;  c_q <= c_d;
      eoc_q <= eoc_d;  busy_q <= busy_d;  err_q <= err_d;
    end
  end

  assign rsa_c = c_q;
  assign eoc   = eoc_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp (WIDTH=8) against a plain-arithmetic modexp model.
module tb_rsa_modexp;

  logic       clk = 1'b0;
  logic       rstb, ena, start_cmd, stop_cmd;
  logic [7:0] rsa_p, rsa_e, rsa_m, rsa_const, rsa_c;
  logic       eoc, busy, err;

  int n_checks = 0;
  int n_fail   = 0;
  int last_c   = 0;

  rsa_modexp #(.WIDTH(8)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .ena       (ena),
    .start_cmd (start_cmd),
    .stop_cmd  (stop_cmd),
    .rsa_p     (rsa_p),
    .rsa_e     (rsa_e),
    .rsa_m     (rsa_m),
    .rsa_const (rsa_const),
    .rsa_c     (rsa_c),
    .eoc       (eoc),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int modexp(input int m, input int e, input int p);
    longint r = 1;
    longint b = m % p;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = (r * b) % p;
      b = (b * b) % p;
    end
    return int'(r % p);
  endfunction

  function automatic int latency(input int e);
`ifdef RSA_CONST_TIME_EN
    return (3 + 2 * 8) * (8 + 2);
`else
    return (3 + 8 + $countones(e[7:0])) * (8 + 2);
`endif
  endfunction

  task automatic set_ops(input int p, input int e, input int m);
    rsa_p     = 8'(p);
    rsa_e     = 8'(e);
    rsa_m     = 8'(m);
    rsa_const = 8'(65536 % p);
  endtask

  // Called at posedge+1. Start is sampled at edge t0; k counts edges after t0.
  task automatic run_op(input int p, input int e, input int m, input int extra_start,
                        input int gap_at, input int gap_len);
    int L, total, busy_cnt, exp_c;
    exp_c    = modexp(m, e, p);
    L        = latency(e);
    total    = L + gap_len;
    busy_cnt = 0;
    set_ops(p, e, m);
    start_cmd = 1'b1;
    @(posedge clk); #1;
    start_cmd = 1'b0;
    set_ops(3, 1, 2);
    for (int k = 1; k <= total; k++) begin
      start_cmd = (k == extra_start);
      ena       = !(gap_len > 0 && k >= gap_at && k < gap_at + gap_len);
      @(posedge clk); #1;
      start_cmd = 1'b0;
      ena       = 1'b1;
      if (busy) busy_cnt++;
      if (k == 1) check("busy_rise", busy, 1);
      if (k == total - 1) check("eoc_early", eoc, 0);
    end
    check("eoc_done", eoc, 1);
    check("busy_done", busy, 0);
    check("err_done", err, 0);
    check("result", rsa_c, exp_c);
    check("busy_len", busy_cnt, L - 1 + gap_len);
    last_c = exp_c;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0; ena = 1'b1; start_cmd = 1'b0; stop_cmd = 1'b0;
    set_ops(11, 3, 5);
    #3;
    check("rst_c", rsa_c, 0);
    check("rst_eoc", eoc, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    #9 rstb = 1'b1;
    @(posedge clk); #1;

    run_op(11, 3, 5, 0, 0, 0);

    // even modulus: immediate error, no computation
    set_ops(10, 3, 5);
    start_cmd = 1'b1;
    @(posedge clk); #1;
    start_cmd = 1'b0;
    @(posedge clk); #1;
    check("even_err", err, 1);
    check("even_eoc", eoc, 1);
    check("even_c", rsa_c, 0);
    check("even_busy", busy, 0);
    last_c = 0;

    stop_cmd = 1'b1;
    @(posedge clk); #1;
    stop_cmd = 1'b0;
    check("idle_stop_eoc", eoc, 0);
    check("idle_stop_err", err, 0);

    // simultaneous start and stop while idle: stop wins
    set_ops(11, 3, 5);
    start_cmd = 1'b1; stop_cmd = 1'b1;
    @(posedge clk); #1;
    start_cmd = 1'b0; stop_cmd = 1'b0;
    @(posedge clk); #1;
    check("startstop_busy", busy, 0);

    run_op(251, 7, 2, 0, 0, 0);
    run_op(11, 0, 5, 0, 0, 0);

    // abort at t0+50
    set_ops(11, 3, 5);
    start_cmd = 1'b1;
    @(posedge clk); #1;
    start_cmd = 1'b0;
    for (int k = 1; k <= 51; k++) begin
      stop_cmd = (k == 50);
      @(posedge clk); #1;
      stop_cmd = 1'b0;
    end
    check("abort_busy", busy, 0);
    check("abort_eoc", eoc, 0);
    check("abort_c", rsa_c, last_c);

    run_op(11, 3, 5, 20, 0, 0);
    run_op(11, 3, 5, 0, 40, 15);

    // asynchronous reset mid-run
    set_ops(11, 3, 5);
    start_cmd = 1'b1;
    @(posedge clk); #1;
    start_cmd = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
    end
    #2 rstb = 1'b0;
    #1;
    check("arst_c", rsa_c, 0);
    check("arst_eoc", eoc, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err, 0);
    #2 rstb = 1'b1;
    @(posedge clk); #1;
    last_c = 0;

    for (int n = 0; n < 12; n++) begin
      int p, e, m;
      p = 2 * int'($urandom_range(127, 1)) + 1;
      m = int'($urandom_range(p - 1, 0));
      e = int'($urandom_range(255, 0));
      run_op(p, e, m, 0, 30, int'($urandom_range(3, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
